// File: rtl/risc_dmem_resp.sv
// Data-memory responder for the RV32 load/store interface: one request at a time,
// optional wait states, little-endian word array, word-crossing accesses split into two beats.
module risc_dmem_resp #(
    parameter int unsigned DEPTH_WORDS      = 1024,
    parameter int unsigned WAIT_STATES      = 1,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BEAT0, S_BEAT1, S_RESP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q;
    logic            we_q, err_q, split_q;
    logic [2:0]      funct3_q;
    logic [31:0]     wdata_q;
    logic [1:0]      off_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     raw_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            accept;
    logic [1:0]      size_in;
    logic [2:0]      nbytes_in;
    logic            legal_in, misaligned_in, split_in, err_in;
    logic [31:0]     word_in;

    logic [AW-1:0]   beat_idx;
    logic [31:0]     rd_word;
    logic [3:0]      lane_mask;
    logic [7:0]      be_all;
    logic [63:0]     wd_all;
    logic [3:0]      beat_be;
    logic [31:0]     beat_wd;
    logic            mem_we;
    logic [63:0]     gathered;
    logic [31:0]     aligned;
    logic [31:0]     ext;
    logic [31:0]     load_data;

    assign accept = req_valid_i && (state_q == S_IDLE);

    // Every error is decided here, at acceptance, so the beats never need to re-check.
    always_comb begin
        size_in = req_funct3_i[1:0];
        case (size_in)
            2'b00:   nbytes_in = 3'd1;
            2'b01:   nbytes_in = 3'd2;
            default: nbytes_in = 3'd4;
        endcase
        legal_in = (size_in != 2'b11) &&
                   (req_we_i ? !req_funct3_i[2] : !(req_funct3_i[2] && size_in == 2'b10));
        misaligned_in = (size_in == 2'b01 && req_addr_i[0]) ||
                        (size_in == 2'b10 && req_addr_i[1:0] != 2'b00);
        split_in = ({1'b0, req_addr_i[1:0]} + nbytes_in) > 3'd4;
        word_in  = {2'b00, req_addr_i[31:2]};
        err_in   = !legal_in
                || (misaligned_in && !ALLOW_MISALIGNED)
                || (word_in >= 32'(DEPTH_WORDS))
                || (split_in && (word_in + 32'd1 >= 32'(DEPTH_WORDS)));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid_i) state_d = (WAIT_STATES > 0) ? S_WAIT : S_BEAT0;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_BEAT0;
            S_BEAT0: state_d = split_q ? S_BEAT1 : S_RESP;
            S_BEAT1: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
        rsp_rdata_o = rsp_rdata_q;
        rsp_err_o   = rsp_err_q;
    end

    // Lanes are laid out as a 64-bit window over word idx and idx+1, shifted by the byte offset.
    always_comb begin
        beat_idx = (state_q == S_BEAT1) ? idx_q + AW'(1) : idx_q;
        rd_word  = mem_q[beat_idx];
        case (funct3_q[1:0])
            2'b00:   lane_mask = 4'b0001;
            2'b01:   lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        be_all   = {4'b0000, lane_mask} << off_q;
        wd_all   = {32'd0, wdata_q} << {off_q, 3'b000};
        beat_be  = (state_q == S_BEAT1) ? be_all[7:4] : be_all[3:0];
        beat_wd  = (state_q == S_BEAT1) ? wd_all[63:32] : wd_all[31:0];
        mem_we   = we_q && !err_q && (state_q == S_BEAT0 || state_q == S_BEAT1);
        gathered = (state_q == S_BEAT1) ? {rd_word, raw_q} : {32'd0, rd_word};
        aligned  = 32'(gathered >> {off_q, 3'b000});
        case (funct3_q[1:0])
            2'b00:   ext = {{24{!funct3_q[2] & aligned[7]}}, aligned[7:0]};
            2'b01:   ext = {{16{!funct3_q[2] & aligned[15]}}, aligned[15:0]};
            default: ext = aligned;
        endcase
        load_data = (we_q || err_q) ? 32'd0 : ext;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            split_q     <= 1'b0;
            funct3_q    <= 3'd0;
            wdata_q     <= 32'd0;
            off_q       <= 2'd0;
            idx_q       <= '0;
            raw_q       <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q    <= WAIT_LOAD;
                        we_q     <= req_we_i;
                        err_q    <= err_in;
                        split_q  <= split_in && !err_in;
                        funct3_q <= req_funct3_i;
                        wdata_q  <= req_wdata_i;
                        off_q    <= req_addr_i[1:0];
                        idx_q    <= req_addr_i[AW+1:2];
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                end
                S_BEAT0: begin
                    raw_q <= rd_word;
                    if (!split_q) begin
                        rsp_rdata_q <= load_data;
                        rsp_err_q   <= err_q;
                    end
                end
                S_BEAT1: begin
                    rsp_rdata_q <= load_data;
                    rsp_err_q   <= err_q;
                end
                S_RESP: begin
                    rsp_rdata_q <= 32'd0;
                    rsp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The array is deliberately not reset; a reset aborts a pending beat because state_q drops to IDLE.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (beat_be[b]) mem_q[beat_idx][8*b +: 8] <= beat_wd[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_risc_dmem_resp.sv
// Self-checking bench for risc_dmem_resp: two instances (split-capable and strict-alignment)
// checked against a byte-addressed reference model.
module tb_risc_dmem_resp;

    logic              clk;
    logic              rst;
    logic [1:0]        reqValid;
    logic [1:0]        reqReady;
    logic [1:0]        reqWe;
    logic [1:0][31:0]  reqAddr;
    logic [1:0][31:0]  reqWdata;
    logic [1:0][2:0]   reqFunct3;
    logic [1:0]        rspValid;
    logic [1:0][31:0]  rspRdata;
    logic [1:0]        rspErr;

    int checks   = 0;
    int failures = 0;

    int depthOf [2] = '{1024, 16};
    int waitOf  [2] = '{1, 0};
    bit allowOf [2] = '{1'b1, 1'b0};

    logic [7:0] refMem [2][4096];

    risc_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .ALLOW_MISALIGNED(1'b1)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid[0]), .req_ready_o(reqReady[0]), .req_we_i(reqWe[0]),
        .req_addr_i(reqAddr[0]), .req_wdata_i(reqWdata[0]), .req_funct3_i(reqFunct3[0]),
        .rsp_valid_o(rspValid[0]), .rsp_rdata_o(rspRdata[0]), .rsp_err_o(rspErr[0])
    );

    risc_dmem_resp #(.DEPTH_WORDS(16), .WAIT_STATES(0), .ALLOW_MISALIGNED(1'b0)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid[1]), .req_ready_o(reqReady[1]), .req_we_i(reqWe[1]),
        .req_addr_i(reqAddr[1]), .req_wdata_i(reqWdata[1]), .req_funct3_i(reqFunct3[1]),
        .rsp_valid_o(rspValid[1]), .rsp_rdata_o(rspRdata[1]), .rsp_err_o(rspErr[1])
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case a wait loop is ever bypassed
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int sizeBytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit isSplit(input logic [31:0] addr, input logic [2:0] f3);
        return (int'(addr % 4) + sizeBytes(f3)) > 4;
    endfunction

    function automatic bit modelErr(input int sel, input bit we, input logic [31:0] addr,
                                    input logic [2:0] f3);
        int n = sizeBytes(f3);
        longint unsigned word = longint'(addr) / 4;
        bit legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
        if ((addr % n) != 0 && !allowOf[sel]) return 1'b1;
        if (word >= longint'(depthOf[sel])) return 1'b1;
        if (isSplit(addr, f3) && word + 1 >= longint'(depthOf[sel])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelLoad(input int sel, input logic [31:0] addr,
                                              input logic [2:0] f3);
        int n = sizeBytes(f3);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[sel][int'(addr) + i];
        if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic void modelStore(input int sel, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [2:0] f3);
        int n = sizeBytes(f3);
        for (int i = 0; i < n; i++) refMem[sel][int'(addr) + i] = wdata[8*i +: 8];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Entered and left #1 after a rising edge; returns right after the accepting edge.
    task automatic applyStimulus(input int sel, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3,
                                 input bit holdValid);
        int guard = 0;
        while (reqReady[sel] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("ready_before_req", {31'd0, reqReady[sel]}, 32'd1);
        reqWe[sel]     = we;
        reqAddr[sel]   = addr;
        reqWdata[sel]  = wdata;
        reqFunct3[sel] = f3;
        reqValid[sel]  = 1'b1;
        @(posedge clk); #1;
        if (!holdValid) reqValid[sel] = 1'b0;
    endtask

    // Latency counts rising edges from acceptance to the edge that samples rsp_valid high.
    task automatic waitResp(input int sel, input int expLat, input bit expErr,
                            input logic [31:0] expData, input string tag);
        int cnt = 0;
        while (rspValid[sel] !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput({tag, ".latency"}, 32'(cnt + 1), 32'(expLat));
        checkOutput({tag, ".err"}, {31'd0, rspErr[sel]}, {31'd0, expErr});
        checkOutput({tag, ".rdata"}, rspRdata[sel], expData);
        @(posedge clk); #1;
        checkOutput({tag, ".pulse_end"}, {30'd0, rspValid[sel], rspErr[sel]}, 32'd0);
        checkOutput({tag, ".rdata_clear"}, rspRdata[sel], 32'd0);
    endtask

    task automatic runTxn(input int sel, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3, input string tag);
        bit          expErr  = modelErr(sel, we, addr, f3);
        int          expLat  = waitOf[sel] + 2 + ((isSplit(addr, f3) && !expErr) ? 1 : 0);
        logic [31:0] expData = 32'd0;
        if (!expErr && !we) expData = modelLoad(sel, addr, f3);
        if (!expErr && we)  modelStore(sel, addr, wdata, f3);
        applyStimulus(sel, we, addr, wdata, f3, 1'b0);
        waitResp(sel, expLat, expErr, expData, tag);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        bit          w;
        int          seen;

        rst       = 1'b1;
        reqValid  = '0;
        reqWe     = '0;
        reqAddr   = '0;
        reqWdata  = '0;
        reqFunct3 = '0;

        // Reset state on both instances
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput("reset.ready", {31'd0, reqReady[s]}, 32'd1);
            checkOutput("reset.valid", {31'd0, rspValid[s]}, 32'd0);
            checkOutput("reset.rdata", rspRdata[s], 32'd0);
            checkOutput("reset.err", {31'd0, rspErr[s]}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the block's test plan
        runTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw_10");
        runTxn(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw_10");
        runTxn(0, 1'b0, 32'h13, 32'h0, 3'd0, "lb_13");
        runTxn(0, 1'b0, 32'h13, 32'h0, 3'd4, "lbu_13");
        runTxn(0, 1'b0, 32'h12, 32'h0, 3'd1, "lh_12");
        runTxn(0, 1'b0, 32'h10, 32'h0, 3'd5, "lhu_10");
        runTxn(0, 1'b1, 32'h11, 32'h12345655, 3'd0, "sb_11");
        runTxn(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw_10_after_sb");

        // Fill the random-test windows so every load has defined data
        for (int i = 0; i < 64; i++)    runTxn(0, 1'b1, 32'(4*i), $urandom, 3'd2, "fill0");
        for (int i = 1016; i < 1024; i++) runTxn(0, 1'b1, 32'(4*i), $urandom, 3'd2, "fill0_top");
        for (int i = 0; i < 16; i++)    runTxn(1, 1'b1, 32'(4*i), $urandom, 3'd2, "fill1");

        runTxn(0, 1'b1, 32'h1E, 32'hA1B2C3D4, 3'd2, "sw_split_1e");
        runTxn(0, 1'b0, 32'h1E, 32'h0, 3'd2, "lw_split_1e");
        runTxn(0, 1'b0, 32'h1C, 32'h0, 3'd2, "lw_1c");
        runTxn(0, 1'b0, 32'h20, 32'h0, 3'd2, "lw_20");
        runTxn(0, 1'b0, 32'h1000, 32'h0, 3'd2, "lw_out_of_range");
        runTxn(0, 1'b0, 32'h20, 32'h0, 3'd3, "load_f3_3");
        runTxn(0, 1'b1, 32'hFFE, 32'h55667788, 3'd2, "sw_split_past_end");
        runTxn(0, 1'b0, 32'hFFC, 32'h0, 3'd2, "lw_last_word");
        runTxn(1, 1'b0, 32'h11, 32'h0, 3'd1, "strict_lh_11");
        runTxn(1, 1'b0, 32'h12, 32'h0, 3'd1, "strict_lh_12");
        runTxn(1, 1'b0, 32'h40, 32'h0, 3'd2, "strict_lw_40");

        // Reset asserted while a split store waits; nothing may be written or answered
        applyStimulus(0, 1'b1, 32'h3E, 32'hCAFEF00D, 3'd2, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("abort.ready", {31'd0, reqReady[0]}, 32'd1);
        checkOutput("abort.valid", {31'd0, rspValid[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rspValid[0] === 1'b1) seen++;
        end
        checkOutput("abort.no_response", 32'(seen), 32'd0);
        runTxn(0, 1'b0, 32'h3C, 32'h0, 3'd2, "abort.word_15");
        runTxn(0, 1'b0, 32'h40, 32'h0, 3'd2, "abort.word_16");

        // Request held through a busy period: the second one is taken only in the next IDLE
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 3'd2, 1'b1);
        reqAddr[0]   = 32'h14;
        reqFunct3[0] = 3'd5;
        checkOutput("hold.busy_ready", {31'd0, reqReady[0]}, 32'd0);
        waitResp(0, 3, 1'b0, modelLoad(0, 32'h10, 3'd2), "hold.first");
        checkOutput("hold.idle_ready", {31'd0, reqReady[0]}, 32'd1);
        @(posedge clk); #1;
        reqValid[0] = 1'b0;
        checkOutput("hold.accepted", {31'd0, reqReady[0]}, 32'd0);
        waitResp(0, 3, 1'b0, modelLoad(0, 32'h14, 3'd5), "hold.second");

        // Randomized traffic on the split-capable instance
        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom % 2);
            if ($urandom % 10 == 0) f = 3'($urandom % 8);
            else if (w)             f = 3'($urandom_range(0, 2));
            else begin
                f = 3'($urandom_range(0, 4));
                if (f > 3'd2) f = f + 3'd1;
            end
            case ($urandom % 10)
                7, 8:    a = 32'($urandom_range(4064, 4095));
                9:       a = $urandom;
                default: a = 32'($urandom_range(0, 251));
            endcase
            d = $urandom;
            runTxn(0, w, a, d, f, "rand0");
        end

        // Randomized traffic on the strict-alignment, zero-wait instance
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom % 2);
            if ($urandom % 8 == 0) f = 3'($urandom % 8);
            else if (w)            f = 3'($urandom_range(0, 2));
            else begin
                f = 3'($urandom_range(0, 4));
                if (f > 3'd2) f = f + 3'd1;
            end
            a = 32'($urandom_range(0, 70));
            d = $urandom;
            runTxn(1, w, a, d, f, "rand1");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
